// File: rtl/fetch_feeder.sv
// Fetch-request sequencer and circular instruction queue between fetch and decode.
// Requests up to DECODE_PARA sequential PCs per cycle, keeps the in-order prefix of
// hits, and hands buffered instructions to decode one per cycle.
module fetch_feeder #(
    parameter int unsigned         LEN_WORD    = 32,
    parameter int unsigned         LEN_INST    = 32,
    parameter int unsigned         DECODE_PARA = 2,
    parameter int unsigned         LOG_DEPTH   = 3,
    parameter logic [LEN_WORD-1:0] RESET_PC    = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic [DECODE_PARA-1:0]          order,
    output logic [LEN_WORD*DECODE_PARA-1:0] pc,
    input  logic [DECODE_PARA-1:0]          done,
    input  logic [LEN_INST*DECODE_PARA-1:0] instr,
    input  logic                            redirect,
    input  logic [LEN_WORD-1:0]             redirect_pc,
    output logic                            deq_valid,
    input  logic                            deq_ready,
    output logic [LEN_WORD-1:0]             deq_pc,
    output logic [LEN_INST-1:0]             deq_instr,
    output logic [LOG_DEPTH:0]              count
);

    localparam int unsigned DEPTH = 1 << LOG_DEPTH;
    localparam int unsigned CW    = LOG_DEPTH + 1;

    logic [LEN_WORD-1:0]  fpc_q, fpc_d;
    logic [LOG_DEPTH-1:0] head_q, head_d;
    logic [LOG_DEPTH-1:0] tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;

    logic [LEN_WORD-1:0]  mem_pc    [DEPTH];
    logic [LEN_INST-1:0]  mem_instr [DEPTH];

    logic [CW-1:0]        free;
    logic [CW-1:0]        k;
    logic                 run;
    logic                 deq_fire;
    logic [LOG_DEPTH-1:0] wr_idx [DECODE_PARA];

    // Request lanes: only as many lanes as there are free slots, from registered count,
    // so neither done nor deq_ready can reach order/pc combinationally.
    always_comb begin
        free  = CW'(DEPTH) - count_q;
        order = '0;
        pc    = '0;
        for (int i = 0; i < int'(DECODE_PARA); i++) begin
            order[i]                     = (int'(free) > i) && !redirect;
            pc[i*LEN_WORD +: LEN_WORD]   = fpc_q + LEN_WORD'(4 * i);
        end
    end

    // Accept count: leading run of ordered hits; a hit after the first miss is dropped.
    always_comb begin
        run = 1'b1;
        k   = '0;
        for (int i = 0; i < int'(DECODE_PARA); i++) begin
            if (run && order[i] && done[i]) begin
                k = k + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Write slots for each lane, wrapping modulo DEPTH.
    always_comb begin
        for (int j = 0; j < int'(DECODE_PARA); j++) begin
            wr_idx[j] = tail_q + LOG_DEPTH'(j);
        end
    end

    // Storage write; k is zero during redirect since order is masked.
    always_ff @(posedge clk) begin
        for (int j = 0; j < int'(DECODE_PARA); j++) begin
            if (int'(k) > j) begin
                mem_pc[wr_idx[j]]    <= pc[j*LEN_WORD +: LEN_WORD];
                mem_instr[wr_idx[j]] <= instr[j*LEN_INST +: LEN_INST];
            end
        end
    end

    // Dequeue side: head entry presented whenever the queue is non-empty.
    always_comb begin
        deq_valid = (count_q != '0) && !redirect;
        deq_fire  = deq_valid && deq_ready;
        deq_pc    = mem_pc[head_q];
        deq_instr = mem_instr[head_q];
        count     = count_q;
    end

    // Next-state: redirect flushes everything, otherwise apply enqueue and dequeue together.
    always_comb begin
        fpc_d   = fpc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            // Mask the byte offset; whole operand used so no bit is left dangling.
            fpc_d   = redirect_pc & ~LEN_WORD'(3);
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            fpc_d   = fpc_q + (LEN_WORD'(k) << 2);
            tail_d  = tail_q + k[LOG_DEPTH-1:0];
            head_d  = deq_fire ? head_q + LOG_DEPTH'(1) : head_q;
            count_d = count_q + k - CW'(deq_fire);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q   <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            fpc_q   <= fpc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_feeder.sv
// Self-checking bench for fetch_feeder with default parameters (2 lanes, depth 8).
module tb_fetch_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  order;
    logic [63:0] pc;
    logic [1:0]  done;
    logic [63:0] instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .order       (order),
        .pc          (pc),
        .done        (done),
        .instr       (instr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_pc      (deq_pc),
        .deq_instr   (deq_instr),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Fetch-stage stand-in: instruction word is a fixed scramble of its PC.
    function automatic logic [31:0] mk(input logic [31:0] p);
        return (p ^ 32'hC0DE_0000) + 32'h0000_0011;
    endfunction

    assign instr = {mk(pc[63:32]), mk(pc[31:0])};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        done = 2'b00;
        deq_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_dv", deq_valid, 0);
        chk("rst_order", order, 2'b11);
        chk("rst_pc", pc, {32'd4, 32'd0});
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  done;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic [1:0]  e_order;
        logic [31:0] e_pc0;
        logic [3:0]  e_count;
        logic        e_dv;
        logic [31:0] e_dpc;
    } vec_t;

    vec_t vecs[13];

    logic [31:0] exp_q[$];
    logic [1:0]  pat[6];

    initial begin
        // Fill, full stall, partial space, redirect, non-prefix hit.
        vecs[0]  = '{2'b11, 1'b0, 1'b0, 32'h0,   2'b11, 32'd0,     4'd0, 1'b0, 32'd0};
        vecs[1]  = '{2'b11, 1'b0, 1'b0, 32'h0,   2'b11, 32'd8,     4'd2, 1'b1, 32'd0};
        vecs[2]  = '{2'b11, 1'b0, 1'b0, 32'h0,   2'b11, 32'd16,    4'd4, 1'b1, 32'd0};
        vecs[3]  = '{2'b11, 1'b0, 1'b0, 32'h0,   2'b11, 32'd24,    4'd6, 1'b1, 32'd0};
        vecs[4]  = '{2'b11, 1'b0, 1'b0, 32'h0,   2'b00, 32'd32,    4'd8, 1'b1, 32'd0};
        vecs[5]  = '{2'b11, 1'b1, 1'b0, 32'h0,   2'b00, 32'd32,    4'd8, 1'b1, 32'd0};
        vecs[6]  = '{2'b11, 1'b0, 1'b0, 32'h0,   2'b01, 32'd32,    4'd7, 1'b1, 32'd4};
        vecs[7]  = '{2'b00, 1'b1, 1'b0, 32'h0,   2'b00, 32'd36,    4'd8, 1'b1, 32'd4};
        vecs[8]  = '{2'b11, 1'b1, 1'b1, 32'h103, 2'b00, 32'd36,    4'd7, 1'b0, 32'd0};
        vecs[9]  = '{2'b10, 1'b1, 1'b0, 32'h0,   2'b11, 32'h100,   4'd0, 1'b0, 32'd0};
        vecs[10] = '{2'b01, 1'b1, 1'b0, 32'h0,   2'b11, 32'h100,   4'd0, 1'b0, 32'd0};
        vecs[11] = '{2'b00, 1'b1, 1'b0, 32'h0,   2'b11, 32'h104,   4'd1, 1'b1, 32'h100};
        vecs[12] = '{2'b00, 1'b0, 1'b0, 32'h0,   2'b11, 32'h104,   4'd0, 1'b0, 32'd0};
        pat[0] = 2'b11; pat[1] = 2'b01; pat[2] = 2'b11;
        pat[3] = 2'b10; pat[4] = 2'b11; pat[5] = 2'b00;

        // ---- Streaming: done=11, deq_ready=1, sequential PCs with no gaps ----
        do_reset();
        begin
            logic [31:0] nxt;
            nxt = 0;
            for (int cyc = 0; cyc < 24; cyc++) begin
                @(negedge clk);
                done = 2'b11;
                deq_ready = 1'b1;
                #1;
                if (cyc == 0) begin
                    chk("stream_first_order", order, 2'b11);
                    chk("stream_first_dv", deq_valid, 0);
                end else begin
                    chk("stream_dv", deq_valid, 1);
                    chk("stream_pc", deq_pc, nxt);
                    chk("stream_instr", deq_instr, mk(nxt));
                    nxt += 4;
                end
            end
        end

        // ---- Table-driven vectors ----
        do_reset();
        for (int v = 0; v < 13; v++) begin
            @(negedge clk);
            done = vecs[v].done;
            deq_ready = vecs[v].rdy;
            redirect = vecs[v].redir;
            redirect_pc = vecs[v].rpc;
            #1;
            chk($sformatf("vec%0d_order", v), order, vecs[v].e_order);
            chk($sformatf("vec%0d_pc", v), pc, {vecs[v].e_pc0 + 32'd4, vecs[v].e_pc0});
            chk($sformatf("vec%0d_count", v), count, vecs[v].e_count);
            chk($sformatf("vec%0d_dv", v), deq_valid, vecs[v].e_dv);
            if (vecs[v].e_dv) begin
                chk($sformatf("vec%0d_dpc", v), deq_pc, vecs[v].e_dpc);
                chk($sformatf("vec%0d_dinstr", v), deq_instr, mk(vecs[v].e_dpc));
            end
        end
        redirect = 1'b0;

        // ---- Redirect with count=5 and deq_ready=1 ----
        do_reset();
        @(negedge clk); done = 2'b11; deq_ready = 1'b0;
        @(negedge clk); done = 2'b11;
        @(negedge clk); done = 2'b01;
        @(negedge clk);
        done = 2'b11; deq_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h2003;
        #1;
        chk("redir_pre_count", count, 5);
        chk("redir_dv_masked", deq_valid, 0);
        chk("redir_order_masked", order, 2'b00);
        @(negedge clk);
        redirect = 1'b0; done = 2'b00;
        #1;
        chk("redir_count", count, 0);
        chk("redir_dv", deq_valid, 0);
        chk("redir_pc", pc, {32'h2004, 32'h2000});
        chk("redir_order", order, 2'b11);
        done = 2'b11;
        @(negedge clk);
        done = 2'b00;
        #1;
        chk("redir_first_dv", deq_valid, 1);
        chk("redir_first_pc", deq_pc, 32'h2000);

        // ---- Wrap-around: 20 instructions, deq_ready toggling ----
        do_reset();
        begin
            int m_count, enq_n, deq_n, kk;
            logic [31:0] m_fpc, e;
            logic [1:0] eo, d;
            logic run;
            m_count = 0; enq_n = 0; deq_n = 0; m_fpc = 0;
            exp_q.delete();
            for (int cyc = 0; cyc < 200 && deq_n < 20; cyc++) begin
                @(negedge clk);
                d = pat[cyc % 6];
                if (enq_n >= 20) d = 2'b00;
                else if (enq_n == 19) d = d & 2'b01;
                done = d;
                deq_ready = (cyc % 2 == 0);
                #1;
                eo = {(8 - m_count) >= 2, (8 - m_count) >= 1};
                chk("wrap_order", order, eo);
                chk("wrap_count", count, m_count);
                chk("wrap_count_le8", count > 4'd8, 0);
                chk("wrap_dv", deq_valid, m_count != 0);
                kk = 0; run = 1'b1;
                for (int j = 0; j < 2; j++) begin
                    if (run && eo[j] && d[j]) begin
                        exp_q.push_back(m_fpc + 32'(4 * j));
                        kk++;
                    end else begin
                        run = 1'b0;
                    end
                end
                enq_n += kk;
                if (m_count != 0 && deq_ready) begin
                    e = exp_q.pop_front();
                    chk("wrap_dpc", deq_pc, e);
                    chk("wrap_dinstr", deq_instr, mk(e));
                    deq_n++;
                    m_count--;
                end
                m_count += kk;
                m_fpc += 32'(4 * kk);
            end
            chk("wrap_all_dequeued", deq_n, 20);
        end

        // ---- Asynchronous reset mid-stream with count=6 ----
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); done = 2'b11; deq_ready = 1'b0;
        end
        @(negedge clk);
        done = 2'b00;
        #1;
        chk("arst_pre_count", count, 6);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_dv", deq_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_pc0", pc[31:0], 32'd0);
        chk("arst_order", order, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
